// File: rtl/xx6812_chain_encoder.sv
// Serial encoder for a chain of XX6812-style LEDs: pulls PIXEL_COUNT pixels over a
// valid/ready stream, shifts them out MSB first as a one-wire waveform, then holds a latch gap.
module xx6812_chain_encoder #(
  parameter int PIXEL_BITS   = 24,
  parameter int PIXEL_COUNT  = 60,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int BIT_CYCLES   = 12,
  parameter int LATCH_CYCLES = 300
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  input  logic                  pixel_valid,
  output logic                  pixel_ready,
  output logic                  serial_data_out,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  underrun
);

  // state | meaning
  // IDLE  | line low, waiting for start
  // FILL  | line low, waiting for the first pixel of the frame
  // SEND  | shifting pixels out, one bit per BIT_CYCLES clocks
  // LATCH | line low for LATCH_CYCLES clocks, then frame_done
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SEND, S_LATCH} state_t;

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (PIXEL_BITS > 1) ? $clog2(PIXEL_BITS) : 1;
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam int NW = $clog2(PIXEL_COUNT + 1);

  localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HI0_FROM   = CW'(BIT_CYCLES - T0H_CYCLES);
  localparam logic [CW-1:0] HI1_FROM   = CW'(BIT_CYCLES - T1H_CYCLES);
  localparam logic [CW-1:0] CYC_ONE    = CW'(1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(PIXEL_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [LW-1:0] LATCH_ONE  = LW'(1);
  localparam logic [NW-1:0] N_PIX      = NW'(PIXEL_COUNT);
  localparam logic [NW-1:0] N_ONE      = NW'(1);

  state_t                  state, state_nxt;
  logic [PIXEL_BITS-1:0]   shadow_q, shadow_nxt;
  logic                    shadow_full, shadow_full_nxt;
  logic [PIXEL_BITS-1:0]   shift_q, shift_nxt;
  logic [CW-1:0]           cyc_cnt, cyc_nxt;
  logic [BW-1:0]           bit_cnt, bit_nxt;
  logic [LW-1:0]           latch_cnt, latch_nxt;
  logic [NW-1:0]           accepted, accepted_nxt;
  logic [NW-1:0]           sent, sent_nxt;
  logic                    busy_nxt, done_nxt, underrun_nxt, line_nxt;
  logic                    handshake;

  assign pixel_ready = busy && !shadow_full && (accepted < N_PIX) && (state != S_LATCH);
  assign handshake   = pixel_valid && pixel_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      shadow_q        <= '0;
      shadow_full     <= 1'b0;
      shift_q         <= '0;
      cyc_cnt         <= '0;
      bit_cnt         <= '0;
      latch_cnt       <= '0;
      accepted        <= '0;
      sent            <= '0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
      underrun        <= 1'b0;
      serial_data_out <= 1'b0;
    end else begin
      state           <= state_nxt;
      shadow_q        <= shadow_nxt;
      shadow_full     <= shadow_full_nxt;
      shift_q         <= shift_nxt;
      cyc_cnt         <= cyc_nxt;
      bit_cnt         <= bit_nxt;
      latch_cnt       <= latch_nxt;
      accepted        <= accepted_nxt;
      sent            <= sent_nxt;
      busy            <= busy_nxt;
      frame_done      <= done_nxt;
      underrun        <= underrun_nxt;
      serial_data_out <= line_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    shadow_nxt      = shadow_q;
    shadow_full_nxt = shadow_full;
    shift_nxt       = shift_q;
    cyc_nxt         = cyc_cnt;
    bit_nxt         = bit_cnt;
    latch_nxt       = latch_cnt;
    accepted_nxt    = accepted;
    sent_nxt        = sent;
    busy_nxt        = busy;
    done_nxt        = 1'b0;
    underrun_nxt    = 1'b0;

    if (handshake) begin
      shadow_nxt      = pixel_data;
      shadow_full_nxt = 1'b1;
      accepted_nxt    = accepted + N_ONE;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_FILL;
          busy_nxt  = 1'b1;
        end
      end
      S_FILL: begin
        if (shadow_full) begin
          shift_nxt       = shadow_q;
          shadow_full_nxt = 1'b0;
          sent_nxt        = sent + N_ONE;
          bit_nxt         = BIT_LAST;
          cyc_nxt         = CYC_LAST;
          state_nxt       = S_SEND;
        end
      end
      S_SEND: begin
        if (cyc_cnt != '0) begin
          cyc_nxt = cyc_cnt - CYC_ONE;
        end else if (bit_cnt != '0) begin
          cyc_nxt   = CYC_LAST;
          bit_nxt   = bit_cnt - BIT_ONE;
          shift_nxt = shift_q << 1;
        end else if (sent == N_PIX) begin
          state_nxt = S_LATCH;
          latch_nxt = LATCH_LAST;
        end else if (shadow_full || handshake) begin
          // a pixel arriving on the final clock bypasses the shadow so the chain sees no gap
          shift_nxt       = shadow_full ? shadow_q : pixel_data;
          shadow_full_nxt = 1'b0;
          sent_nxt        = sent + N_ONE;
          bit_nxt         = BIT_LAST;
          cyc_nxt         = CYC_LAST;
        end else begin
          underrun_nxt = 1'b1;
          state_nxt    = S_LATCH;
          latch_nxt    = LATCH_LAST;
        end
      end
      S_LATCH: begin
        if (latch_cnt == '0) begin
          state_nxt       = S_IDLE;
          busy_nxt        = 1'b0;
          done_nxt        = 1'b1;
          accepted_nxt    = '0;
          sent_nxt        = '0;
          shadow_full_nxt = 1'b0;
        end else begin
          latch_nxt = latch_cnt - LATCH_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // high for the first T0H/T1H clocks of each bit, counted on the down-counter
    line_nxt = (state_nxt == S_SEND) &&
               (shift_nxt[PIXEL_BITS-1] ? (cyc_nxt >= HI1_FROM) : (cyc_nxt >= HI0_FROM));
  end

endmodule

// File: tb/tb_xx6812_chain_encoder.sv
// Scoreboard bench: the driver queues expected bits/frames, negedge monitors decode
// the LED waveform and compare against those queues.
`timescale 1ns/1ps
module tb_xx6812_chain_encoder;
  localparam int PB = 24, PC = 2, T0H = 2, T1H = 4, BITC = 6, LATCH = 10;

  logic clock = 1'b0, clk_run = 1'b0, reset = 1'b0;
  logic start = 1'b0, pixel_valid = 1'b0;
  logic [PB-1:0] pixel_data = '0;
  logic pixel_ready, serial_data_out, busy, frame_done, underrun;

  logic start32 = 1'b0, valid32 = 1'b0;
  logic [31:0] data32 = '0;
  logic ready32, serial32, busy32, frame_done32, underrun32;

  always #5 if (clk_run) clock = ~clock;

  xx6812_chain_encoder #(.PIXEL_BITS(PB), .PIXEL_COUNT(PC), .T0H_CYCLES(T0H),
    .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .LATCH_CYCLES(LATCH)) dut (
    .clock(clock), .reset(reset), .start(start), .pixel_data(pixel_data),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .serial_data_out(serial_data_out),
    .busy(busy), .frame_done(frame_done), .underrun(underrun));

  xx6812_chain_encoder #(.PIXEL_BITS(32), .PIXEL_COUNT(1), .T0H_CYCLES(T0H),
    .T1H_CYCLES(T1H), .BIT_CYCLES(BITC), .LATCH_CYCLES(LATCH)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .pixel_data(data32),
    .pixel_valid(valid32), .pixel_ready(ready32), .serial_data_out(serial32),
    .busy(busy32), .frame_done(frame_done32), .underrun(underrun32));

  int n_vec = 0, n_err = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct { int nbits; bit under; int nhs; } frame_t;
  bit     exp_bits[$];
  frame_t exp_frames[$];
  bit     q32[$];

  // ---------------- monitor for the 24-bit chain ----------------
  int sn = 0, c = 0, h = 0, fbits = 0, first_rise = 0, last_end = 0, hs_n = 0, first_hs = -1;
  bit in_bit = 0, under_seen = 0, eb = 0;
  frame_t mf;

  always @(negedge clock) begin
    sn++;
    if (reset) begin
      exp_bits.delete(); exp_frames.delete();
      in_bit = 0; fbits = 0; under_seen = 0; hs_n = 0; first_hs = -1;
    end else begin
      if (pixel_valid && pixel_ready) begin
        if (hs_n == 0) first_hs = sn;
        hs_n++;
      end
      if (in_bit) begin
        c++;
        if (serial_data_out && h == c - 1) h++;
        else if (serial_data_out) chk("line_high_after_low", serial_data_out, 1'b0);
        if (c == BITC) begin
          in_bit = 0;
          if (exp_bits.size() == 0) chk("unexpected_bit", exp_bits.size(), 1);
          else begin
            eb = exp_bits.pop_front();
            chk("bit_high_time", h, eb ? T1H : T0H);
          end
          fbits++;
          last_end = sn;
        end
      end else if (serial_data_out) begin
        if (fbits == 0) begin
          first_rise = sn;
          chk("first_rise_latency", sn - first_hs, 2);
        end else chk("bit_gap", sn - last_end, 1);
        in_bit = 1; c = 1; h = 1;
      end
      if (underrun) begin
        under_seen = 1;
        chk("underrun_timing", sn - last_end, 1);
      end
      if (frame_done) begin
        if (exp_frames.size() == 0) chk("unexpected_frame_done", exp_frames.size(), 1);
        else begin
          mf = exp_frames.pop_front();
          chk("frame_bits", fbits, mf.nbits);
          chk("frame_length", last_end - first_rise + 1, mf.nbits * BITC);
          chk("latch_gap", sn - last_end, LATCH + 1);
          chk("underrun_flag", under_seen, mf.under);
          chk("handshakes", hs_n, mf.nhs);
          chk("busy_at_done", busy, 1'b0);
        end
        fbits = 0; under_seen = 0; hs_n = 0; first_hs = -1;
      end
    end
  end

  // ---------------- monitor for the 32-bit single-pixel chain ----------------
  int s32 = -1, done32_cnt = 0;
  bit b32 = 0;
  always @(negedge clock) begin
    if (reset) s32 = -1;
    else begin
      if (frame_done32) done32_cnt++;
      if (s32 < 0 && serial32) s32 = 0;
      if (s32 >= 0) begin
        if (s32 < 32 * BITC) begin
          if (q32.size() != 32) chk("p32_queue", q32.size(), 32);
          else begin
            b32 = q32[s32 / BITC];
            chk("p32_line", serial32, ((s32 % BITC) < (b32 ? T1H : T0H)) ? 1'b1 : 1'b0);
          end
          s32++;
        end else if (s32 < 32 * BITC + LATCH) begin
          chk("p32_latch_low", {serial32, frame_done32}, 2'b00);
          s32++;
        end else begin
          chk("p32_frame_done", {frame_done32, busy32}, 2'b10);
          q32.delete();
          s32 = -1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    for (int t = 0; t < 5000 && busy; t++) begin @(posedge clock); #1; end
    chk("frame_end_timeout", busy, 1'b0);
  endtask

  task automatic drive_pixel(input logic [PB-1:0] p, input int dly, input bit xstart);
    pixel_valid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      if (xstart && i == 20) start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
    end
    pixel_data  = p;
    pixel_valid = 1'b1;
    for (int t = 0; t <= 2000; t++) begin
      if (pixel_ready) begin
        @(posedge clock);
        for (int b = PB - 1; b >= 0; b--) exp_bits.push_back(p[b]);
        #1;
        pixel_valid = 1'b0;
        return;
      end
      @(posedge clock); #1;
    end
    chk("handshake_timeout", pixel_ready, 1'b1);
    pixel_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [PB-1:0] p0, input logic [PB-1:0] p1,
                            input int nsup, input int d0, input int gap, input bit xstart);
    frame_t f;
    f.nbits = nsup * PB;
    f.under = (nsup < PC);
    f.nhs   = nsup;
    exp_frames.push_back(f);
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("ready_after_start", pixel_ready, 1'b1);
    for (int i = 0; i < nsup; i++)
      drive_pixel(i == 0 ? p0 : p1, i == 0 ? d0 : gap, xstart && i == 0);
    wait_idle();
    pixel_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("ready_after_frame", pixel_ready, 1'b0);
      @(posedge clock); #1;
    end
    pixel_valid = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1;
    chk("reset_outputs", {serial_data_out, busy, pixel_ready, frame_done, underrun}, 5'b0);
    chk("reset_outputs_32", {serial32, busy32, ready32, frame_done32, underrun32}, 5'b0);
    #2 clk_run = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    send_frame(24'hA50000, 24'h00FF01, 2, 0, 0, 1'b0);
    send_frame(24'hFFFFFF, 24'h000000, 1, 0, 0, 1'b0);
    send_frame(24'($urandom), 24'($urandom), 2, 50, 0, 1'b1);
    send_frame(24'($urandom), 24'($urandom), 2, 3, 144, 1'b0);
    for (int k = 0; k < 4; k++)
      send_frame(24'($urandom), 24'($urandom), 2, $urandom_range(0, 20), $urandom_range(0, 140), 1'b0);

    // reset in the middle of SEND
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    drive_pixel(24'($urandom), 0, 1'b0);
    for (int t = 0; t < 20 && !serial_data_out; t++) begin @(posedge clock); #1; end
    repeat (99) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("reset_mid_outputs", {serial_data_out, busy, pixel_ready, frame_done, underrun}, 5'b0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    repeat (20) begin
      @(posedge clock); #1;
      chk("idle_after_reset", {busy, frame_done}, 2'b00);
    end
    send_frame(24'($urandom), 24'($urandom), 2, $urandom_range(0, 10), $urandom_range(0, 100), 1'b0);

    // 32-bit single-pixel instance
    @(posedge clock); #1 start32 = 1'b1;
    @(posedge clock); #1 start32 = 1'b0;
    data32 = 32'h80000001;
    valid32 = 1'b1;
    for (int t = 0; t < 100 && !ready32; t++) begin @(posedge clock); #1; end
    chk("p32_ready", ready32, 1'b1);
    @(posedge clock);
    for (int b = 31; b >= 0; b--) q32.push_back(data32[b]);
    #1 valid32 = 1'b0;
    for (int t = 0; t < 2000 && busy32; t++) begin @(posedge clock); #1; end
    chk("p32_busy_end", busy32, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("p32_frames", done32_cnt, 1);

    chk("leftover_frames", exp_frames.size(), 0);
    chk("leftover_bits", exp_bits.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, vectors %0d miscompares %0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
